mult_cmd_issuer: RTL
====================

MULT_CMD_ISSUER -- requirements
Module: mult_cmd_issuer

Interface
REQ-001 Parameter DEPTH, 4, operand FIFO entries (power of two, >=2).
REQ-002 Parameter TIMEOUT, 64, max cycles waited for result_rdy after ack.
REQ-003 Reset rst_n, asynchronous, active-low; clock clk. All state elements SHALL use posedge clk.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  async active-low reset.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  FIFO can accept.
REQ-008 in_a, in_b  in  16 signed  operands.
REQ-009 in_inj_a, in_inj_b  in  1  invert generated parity of A/B (error injection).
REQ-010 req  out  1  request to multiplier.
REQ-011 arg_a, arg_b  out  16 signed  operands to multiplier.
REQ-012 arg_a_parity, arg_b_parity  out  1  operand parity to multiplier.
REQ-013 ack  in  1  multiplier accepted operands.
REQ-014 result  in  32 signed  multiplier product.
REQ-015 result_parity  in  1  product parity from multiplier.
REQ-016 result_rdy  in  1  product valid (single-cycle pulse).
REQ-017 arg_parity_error  in  1  multiplier flagged bad operand parity; valid with result_rdy.
REQ-018 out_valid  out  1  completed transaction available.
REQ-019 out_ready  in  1  consumer accepts.
REQ-020 out_result  out  32 signed  captured product.
REQ-021 out_status  out  2  00 ok, 01 arg parity error, 10 result parity mismatch, 11 timeout.
REQ-022 busy  out  1  FSM not in IDLE or FIFO non-empty.

Function
REQ-023 Push when in_valid && in_ready; entry = {in_a, in_b, in_inj_a, in_inj_b}; in_ready = !full, registered; no bypass when full.
REQ-024 Parity: arg_x_parity = XOR of the 16 bits of arg_x, XOR in_inj_x.
REQ-025 FSM states IDLE, REQ, WAIT_RES, OUT; one transaction in flight at a time.
REQ-026 IDLE: FIFO non-empty -> pop head, load arg_a/arg_b/parities, req=1 from next cycle, go REQ; push at edge N into empty FIFO gives req=1 after edge N+1.
REQ-027 arg_a, arg_b and parities SHALL stay stable from req rise until WAIT_RES exits.
REQ-028 REQ: ack sampled 1 -> req=0 after that edge, clear timeout counter, go WAIT_RES; ack outside REQ ignored.
REQ-029 WAIT_RES: result_rdy=1 -> capture result into out_result, go OUT; status = 01 if arg_parity_error, else 10 if XOR(result) != result_parity, else 00 (arg error has priority).
REQ-030 WAIT_RES: counter increments each cycle without result_rdy; counter reaching TIMEOUT -> out_result=0, status 11, go OUT; result_rdy on the same edge as the limit wins.
REQ-031 result_rdy outside WAIT_RES SHALL be ignored.
REQ-032 OUT: out_valid=1, out_result/out_status held stable until out_ready sampled 1; then out_valid=0, go IDLE.
REQ-033 FIFO push and pop on the same edge SHALL both take effect; pointers wrap modulo DEPTH.
REQ-034 Up to DEPTH buffered entries plus one in flight are accepted before in_ready drops.

Reset
REQ-035 rst_n low SHALL immediately force req=0, out_valid=0, out_result=0, out_status=00, arg_* and parities=0, busy=0, FSM=IDLE, FIFO empty, counter=0.
REQ-036 in_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-037 Reset mid-transaction SHALL discard the in-flight and buffered entries; no output produced for them.

Verification
REQ-038 Push A=3, B=-2; ack 2 cycles later; result_rdy with result=0xFFFFFFFA, correct parity -> arg_a_parity=0, arg_b_parity=1, out_result=0xFFFFFFFA, status 00.
REQ-039 Push A=1, in_inj_a=1 -> arg_a_parity=0; multiplier returns arg_parity_error=1 -> status 01.
REQ-040 Result 0x00000001 with result_parity=0 -> status 10, out_result=1.
REQ-041 No result_rdy for TIMEOUT cycles after ack -> status 11, out_result=0; late result_rdy afterwards ignored.
REQ-042 ack delayed, out_ready=0, 6 back-to-back pushes -> 5 accepted, in_ready=0 on 6th; drain yields results in push order.
REQ-043 rst_n low while req=1 with 2 entries buffered -> req=0 asynchronously, out_valid=0; after release in_ready=1, busy=0, no stale output.

Source files
------------

// File: rtl/mult_cmd_issuer_if.sv
// Bundle of the handshake and data signals around mult_cmd_issuer.
//   master : the issuer side. It drives in_ready, req, arg_*, out_valid, out_result,
//            out_status and busy.
//   slave  : the environment side. This is the operand producer, the multiplier and
//            the result consumer.
// Operand side   : in_valid/in_ready, in_a, in_b, in_inj_a, in_inj_b
// Multiplier side: req/ack, arg_a, arg_b, arg_*_parity, result, result_parity,
//                  result_rdy, arg_parity_error
// Result side    : out_valid/out_ready, out_result, out_status
// Status         : busy
interface mult_cmd_issuer_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_a;
   logic signed [15:0] in_b;
   logic               in_inj_a;
   logic               in_inj_b;

   logic               req;
   logic signed [15:0] arg_a;
   logic signed [15:0] arg_b;
   logic               arg_a_parity;
   logic               arg_b_parity;
   logic               ack;
   logic signed [31:0] result;
   logic               result_parity;
   logic               result_rdy;
   logic               arg_parity_error;

   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] out_result;
   logic [1:0]         out_status;
   logic               busy;

   modport master (
      input  in_valid, in_a, in_b, in_inj_a, in_inj_b,
      input  ack, result, result_parity, result_rdy, arg_parity_error,
      input  out_ready,
      output in_ready, req, arg_a, arg_b, arg_a_parity, arg_b_parity,
      output out_valid, out_result, out_status, busy
   );

   modport slave (
      output in_valid, in_a, in_b, in_inj_a, in_inj_b,
      output ack, result, result_parity, result_rdy, arg_parity_error,
      output out_ready,
      input  in_ready, req, arg_a, arg_b, arg_a_parity, arg_b_parity,
      input  out_valid, out_result, out_status, busy
   );
endinterface

// File: rtl/mult_cmd_issuer.sv
// Multiplier command issuer.
// Operand pairs are buffered in a DEPTH-entry FIFO. They are issued one at a time to an
// external multiplier through a req/ack handshake. The issuer then waits up to TIMEOUT
// cycles for the product, checks it, and presents the product with a status code on an
// out_valid/out_ready port.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_cmd_issuer_if.master. Carries the operand, multiplier and result signals.
// out_status codes:
//   00 : ok
//   01 : arg parity error
//   10 : result parity mismatch
//   11 : timeout
module mult_cmd_issuer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   mult_cmd_issuer_if.master  bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] STAT_OK      = 2'b00;
   localparam logic [1:0] STAT_ARG_ERR = 2'b01;
   localparam logic [1:0] STAT_RES_ERR = 2'b10;
   localparam logic [1:0] STAT_TIMEOUT = 2'b11;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        inj_a;
      logic        inj_b;
   } entry_t;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWaitRes,
      StOut
   } state_e;

   // FIFO state
   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   count_d;
   logic               in_ready_q;
   logic               push;
   logic               pop;
   entry_t             head;
   entry_t             wr_entry;

   // Issuer state
   state_e             state_q;
   logic               req_q;
   logic [15:0]        arg_a_q;
   logic [15:0]        arg_b_q;
   logic               arg_a_par_q;
   logic               arg_b_par_q;
   logic [TMO_W-1:0]   tmo_cnt_q;
   logic               out_valid_q;
   logic [31:0]        out_result_q;
   logic [1:0]         out_status_q;

   // ---------------------------------------------------------------------------------
   // Operand FIFO
   // ---------------------------------------------------------------------------------
   assign push     = bus.in_valid & in_ready_q;
   // Only IDLE consumes the head. This keeps a single transaction in flight.
   assign pop      = (state_q == StIdle) && (count_q != '0);
   assign head     = mem_q[rd_ptr_q];
   assign wr_entry = '{a: bus.in_a, b: bus.in_b, inj_a: bus.in_inj_a, inj_b: bus.in_inj_b};

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q    <= count_d;
         // Registered ready. No bypass, so a full FIFO refuses even when a pop happens
         // on the same edge.
         in_ready_q <= (count_d != CNT_W'(DEPTH));
      end
   end

   // ---------------------------------------------------------------------------------
   // Issue / result FSM
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         req_q        <= 1'b0;
         arg_a_q      <= '0;
         arg_b_q      <= '0;
         arg_a_par_q  <= 1'b0;
         arg_b_par_q  <= 1'b0;
         tmo_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_status_q <= STAT_OK;
      end else begin
         case (state_q)
            StIdle: begin
               if (pop) begin
                  // Operands and parities stay held until the next pop.
                  arg_a_q     <= head.a;
                  arg_b_q     <= head.b;
                  arg_a_par_q <= (^head.a) ^ head.inj_a;
                  arg_b_par_q <= (^head.b) ^ head.inj_b;
                  req_q       <= 1'b1;
                  state_q     <= StReq;
               end
            end
            StReq: begin
               if (bus.ack) begin
                  req_q     <= 1'b0;
                  tmo_cnt_q <= '0;
                  state_q   <= StWaitRes;
               end
            end
            StWaitRes: begin
               // A result on the same edge as the limit takes priority over the timeout.
               if (bus.result_rdy) begin
                  out_result_q <= bus.result;
                  if (bus.arg_parity_error) begin
                     out_status_q <= STAT_ARG_ERR;
                  end else if ((^bus.result) != bus.result_parity) begin
                     out_status_q <= STAT_RES_ERR;
                  end else begin
                     out_status_q <= STAT_OK;
                  end
                  out_valid_q <= 1'b1;
                  state_q     <= StOut;
               end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                  // This edge would take the counter to TIMEOUT.
                  out_result_q <= '0;
                  out_status_q <= STAT_TIMEOUT;
                  out_valid_q  <= 1'b1;
                  state_q      <= StOut;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            StOut: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------
   assign bus.in_ready     = in_ready_q;
   assign bus.req          = req_q;
   assign bus.arg_a        = arg_a_q;
   assign bus.arg_b        = arg_b_q;
   assign bus.arg_a_parity = arg_a_par_q;
   assign bus.arg_b_parity = arg_b_par_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_result   = out_result_q;
   assign bus.out_status   = out_status_q;
   assign bus.busy         = (state_q != StIdle) || (count_q != '0);

endmodule
